// File: rtl/ivs_dma_pkg.sv
// Shared types and constants for the IVS read-DMA engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ivs_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         BOUNDARY_4K    = 4096;

  // Ceiling log2, used to derive arsize from the data-bus width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/ivs_skid.sv
// Two-entry registered skid buffer between the AXI R channel and the output stream.
// Latency: one cycle from input handshake to out_valid; full throughput when out_ready stays high.
// Backpressure: in_ready drops only when both entries are occupied; order is preserved.
module ivs_skid #(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] e0_q;   // head entry, drives the output directly
  logic [W-1:0] e1_q;   // overflow entry, only used while the head is stalled
  logic [1:0]   cnt_q;
  logic         push;
  logic         pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = e0_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Occupancy and entry shuffling; the head is refilled from the input or from e1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push) begin
            e0_q  <= in_data;
            cnt_q <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            e0_q <= in_data;
          end else if (push) begin
            e1_q  <= in_data;
            cnt_q <= 2'd2;
          end else if (pop) begin
            cnt_q <= 2'd0;
          end
        end
        default: begin
          // Full: no push possible, a pop promotes the overflow entry.
          if (pop) begin
            e0_q  <= e1_q;
            cnt_q <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ivs_dma_rd.sv
// AXI read-DMA: splits a beat-count transfer into INCR bursts and streams the data out (IVS_DMA_RD_4K_EN adds 4 KB-safe bursts).
// Latency: start -> arvalid next cycle; R beat -> ovalid next cycle; olast handshake -> done next cycle.
// Backpressure: oready stalls the skid buffer, rready drops once both skid entries are full.
module ivs_dma_rd #(
  parameter int         DW      = 128,
  parameter int         AW      = 32,
  parameter int         MAX_LEN = 16,
  parameter logic [3:0] AXI_ID  = 4'h0
) (
  input  logic          aclk,
  input  logic          arst,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [15:0]   total_beats,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          arvalid,
  input  logic          arready,
  output logic [AW-1:0] araddr,
  output logic [5:0]    arlen,
  output logic [2:0]    arsize,
  output logic [1:0]    arburst,
  output logic [3:0]    arid,
  input  logic          rvalid,
  output logic          rready,
  input  logic [DW-1:0] rdata,
  input  logic          rlast,
  input  logic [1:0]    rresp,
  input  logic [3:0]    rid,
  output logic          ovalid,
  input  logic          oready,
  output logic [DW-1:0] odata,
  output logic          olast
);

  import ivs_dma_pkg::*;

  localparam int BYTES = DW / 8;
  localparam int SIZE  = clog2(BYTES);

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] addr_q;      // start address of the current burst
  logic [15:0]   rem_q;       // beats left, including the current burst
  logic [6:0]    len_q;       // beats in the current burst
  logic [6:0]    cnt_q;       // R handshakes seen in the current burst
  logic          err_q;
  logic          done_q;
  logic [5:0]    arlen_q;
  logic [2:0]    arsize_q;
  logic [1:0]    arburst_q;
  logic [3:0]    arid_q;

  logic          r_fire;
  logic [6:0]    cnt_inc;
  logic          beat_is_end;
  logic          burst_end;
  logic [15:0]   rem_after;
  logic [AW-1:0] addr_after;
  logic          xfer_last;
  logic [AW-1:0] src_aligned;
  logic [AW-1:0] ld_addr;
  logic [15:0]   ld_rem;
  logic [16:0]   len_cap;
  logic [6:0]    ld_len;

  logic          skid_in_valid;
  logic          skid_in_ready;
  logic          skid_out_valid;
  logic [DW:0]   skid_out_data;
  logic          pop_last;

  assign r_fire      = rvalid & rready;
  assign cnt_inc     = cnt_q + 7'd1;
  assign beat_is_end = (cnt_inc == len_q);
  assign burst_end   = r_fire & beat_is_end;
  assign rem_after   = rem_q - {9'd0, len_q};
  assign addr_after  = addr_q + (AW'(len_q) << SIZE);
  assign xfer_last   = beat_is_end & (rem_after == 16'd0);
  assign src_aligned = src_addr & ~AW'(BYTES - 1);

  // The next burst is described either by the new request or by what the finished burst leaves.
  assign ld_addr = (state_q == IDLE) ? src_aligned : addr_after;
  assign ld_rem  = (state_q == IDLE) ? total_beats : rem_after;

  // Burst length: remaining beats capped by MAX_LEN and, optionally, by the 4 KB page end.
  always_comb begin
    len_cap = (ld_rem > 16'(MAX_LEN)) ? 17'(MAX_LEN) : {1'b0, ld_rem};
`ifdef IVS_DMA_RD_4K_EN
    begin
      logic [16:0] dist_4k;
      dist_4k = (17'(BOUNDARY_4K) - {5'd0, ld_addr[11:0]}) >> SIZE;
      if (dist_4k < len_cap) len_cap = dist_4k;
    end
`endif
    ld_len = len_cap[6:0];
  end

  // Output stream side: the last beat of the whole transfer is tagged alongside the data.
  assign skid_in_valid = rvalid & (state_q == DATA);
  assign rready        = skid_in_ready & (state_q == DATA);
  assign ovalid        = skid_out_valid;
  assign odata         = skid_out_data[DW-1:0];
  assign olast         = skid_out_valid & skid_out_data[DW];
  assign pop_last      = ovalid & oready & olast;

  ivs_skid #(
    .W(DW + 1)
  ) u_skid (
    .clk       (aclk),
    .rst       (arst),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .in_data   ({xfer_last, rdata}),
    .out_valid (skid_out_valid),
    .out_ready (oready),
    .out_data  (skid_out_data)
  );

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign arvalid = (state_q == ADDR);
  assign araddr  = addr_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;
  assign arburst = arburst_q;
  assign arid    = arid_q;

  // State register.
  always_ff @(posedge aclk) begin
    if (arst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; only one burst is ever outstanding.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (total_beats != 16'd0)) state_d = ADDR;
      ADDR:    if (arready) state_d = DATA;
      DATA:    if (burst_end) state_d = (rem_after != 16'd0) ? ADDR : FLUSH;
      FLUSH:   if (pop_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst bookkeeping, AR field registers, error and done status.
  always_ff @(posedge aclk) begin
    if (arst) begin
      addr_q    <= '0;
      rem_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      arid_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            err_q <= 1'b0;
            if (total_beats == 16'd0) begin
              done_q <= 1'b1;
            end else begin
              addr_q    <= ld_addr;
              rem_q     <= ld_rem;
              len_q     <= ld_len;
              cnt_q     <= '0;
              arlen_q   <= 6'(ld_len - 7'd1);
              arsize_q  <= 3'(SIZE);
              arburst_q <= AXI_BURST_INCR;
              arid_q    <= AXI_ID;
            end
          end
        end
        DATA: begin
          if (r_fire) begin
            cnt_q <= cnt_inc;
            // The beat counter owns burst termination; rlast is only checked.
            if (rlast != beat_is_end) err_q <= 1'b1;
            if ((rresp != AXI_RESP_OKAY) || (rid != AXI_ID)) err_q <= 1'b1;
            if (burst_end) begin
              addr_q  <= ld_addr;
              rem_q   <= ld_rem;
              len_q   <= ld_len;
              cnt_q   <= '0;
              arlen_q <= 6'(ld_len - 7'd1);
            end
          end
        end
        FLUSH: begin
          if (pop_last) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ivs_dma_rd.sv
module tb_ivs_dma_rd;

  localparam int DW    = 128;
  localparam int AW    = 32;
  localparam int BYTES = DW / 8;

  logic          aclk;
  logic          arst;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [15:0]   total_beats;
  logic          busy, done, err;
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic [5:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [3:0]    arid;
  logic          rvalid, rready;
  logic [DW-1:0] rdata;
  logic          rlast;
  logic [1:0]    rresp;
  logic [3:0]    rid;
  logic          ovalid, oready;
  logic [DW-1:0] odata;
  logic          olast;

  ivs_dma_rd #(.DW(DW), .AW(AW), .MAX_LEN(16), .AXI_ID(4'h0)) dut (
    .aclk(aclk), .arst(arst), .start(start), .src_addr(src_addr), .total_beats(total_beats),
    .busy(busy), .done(done), .err(err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rresp(rresp), .rid(rid),
    .ovalid(ovalid), .oready(oready), .odata(odata), .olast(olast)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int out_cnt = 0;
  int racc = 0;
  int bidx = 0;
  int err_beat = 0;

  logic [DW:0]   exp_q[$];   // {olast, odata}
  logic [37:0]   ar_q[$];    // {araddr, arlen}

  function automatic logic [DW-1:0] pat(input logic [31:0] a);
    return {a ^ 32'h5a5a_0000, ~a, a, a + 32'd7};
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event expected none/other", name);
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [5:0] len);
    ar_q.push_back({a, len});
  endtask

  task automatic push_xfer(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), pat(a + 32'(i * BYTES))});
  endtask

  // Simple AXI slave: one burst at a time, data derived from the beat address.
  initial begin : axi_slave
    logic        ar_f, r_f;
    logic [31:0] cap_addr, a;
    int          cap_len, left;
    arready = 0; rvalid = 0; rdata = '0; rlast = 0; rresp = 0; rid = 0;
    a = 0; left = 0; cap_addr = 0; cap_len = 0;
    forever begin
      @(negedge aclk);
      ar_f = arvalid && arready && !arst;
      r_f  = rvalid && rready && !arst;
      if (ar_f) begin
        cap_addr = araddr;
        cap_len  = int'(arlen) + 1;
      end
      @(posedge aclk);
      #1;
      if (arst) begin
        arready = 0; rvalid = 0; rlast = 0; left = 0;
      end else begin
        if (ar_f) begin
          a = cap_addr; left = cap_len; arready = 0;
        end
        if (r_f) begin
          a = a + BYTES; left--; racc++;
          rvalid = 0; rlast = 0; rresp = 0;
        end
        if (!rvalid && left > 0) begin
          bidx++;
          rvalid = 1;
          rdata  = pat(a);
          rlast  = (left == 1);
          rresp  = (bidx == err_beat) ? 2'b10 : 2'b00;
          rid    = 4'h0;
        end
        if (left == 0 && !rvalid) arready = 1;
      end
    end
  end

  // Output stream monitor.
  initial begin : out_mon
    logic [DW:0] e;
    forever begin
      @(negedge aclk);
      if (!arst && ovalid && oready) begin
        out_cnt++;
        if (exp_q.size() == 0) fail("out_extra");
        else begin
          e = exp_q.pop_front();
          chk("odata", {olast, odata}, e);
        end
      end
    end
  end

  // AR channel monitor.
  initial begin : ar_mon
    logic [37:0] e;
    forever begin
      @(negedge aclk);
      if (!arst && arvalid && arready) begin
        if (ar_q.size() == 0) fail("ar_extra");
        else begin
          e = ar_q.pop_front();
          chk("ar_addr_len", {araddr, arlen}, e);
          chk("ar_consts", {arsize, arburst, arid}, {3'd4, 2'b01, 4'h0});
        end
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge aclk);
      if (done) done_cnt++;
    end
  end

  task automatic kick(input logic [31:0] a, input int n);
    @(posedge aclk); #1;
    start = 1; src_addr = a; total_beats = n[15:0];
    @(posedge aclk); #1;
    start = 0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    do begin
      @(negedge aclk);
      k++;
    end while (!done && k < 3000);
    if (!done) fail({name, "_timeout"});
    else chk({name, "_busy_at_done"}, busy, 0);
  endtask

  task automatic tail(input string name, input int d0);
    repeat (3) @(negedge aclk);
    chk({name, "_done_once"}, done_cnt - d0, 1);
    chk({name, "_drained"}, exp_q.size() + ar_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0, k, acc0;
    arst = 1; start = 0; src_addr = '0; total_beats = '0; oready = 1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_ctrl", {arvalid, rready, ovalid, olast, busy, done, err}, 0);
    chk("rst_ar", {araddr, arlen, arsize, arburst, arid}, 0);
    chk("rst_odata", odata, 0);
    @(posedge aclk); #1;
    arst = 0;
    repeat (2) @(posedge aclk);

    // 40 beats split into 16/16/8.
    push_ar(32'h1000, 6'd15); push_ar(32'h1100, 6'd15); push_ar(32'h1200, 6'd7);
    push_xfer(32'h1000, 40);
    d0 = done_cnt;
    kick(32'h1000, 40);
    @(negedge aclk);
    chk("t1_arvalid_t1", {busy, arvalid}, 2'b11);
    wait_done("t1");
    tail("t1", d0);

    // Burst near a 4 KB page end.
`ifdef IVS_DMA_RD_4K_EN
    push_ar(32'h1FC0, 6'd3); push_ar(32'h2000, 6'd11);
`else
    push_ar(32'h1FC0, 6'd15);
`endif
    push_xfer(32'h1FC0, 16);
    d0 = done_cnt;
    kick(32'h1FC0, 16);
    wait_done("t2");
    tail("t2", d0);

    // Output stalled for 10 cycles mid-transfer.
    push_ar(32'h3000, 6'd15); push_ar(32'h3100, 6'd15);
    push_xfer(32'h3000, 32);
    d0 = done_cnt;
    kick(32'h3000, 32);
    k = 0;
    while (out_cnt < 4 + 40 + 16 && k < 500) begin
      @(negedge aclk);
      k++;
    end
    if (k >= 500) fail("t3_wait_out");
    @(posedge aclk); #1;
    oready = 0;
    @(negedge aclk);
    acc0 = racc;
    repeat (4) @(negedge aclk);
    chk("t3_stall_rready_ovalid", {rready, ovalid}, 2'b01);
    repeat (5) @(negedge aclk);
    chk("t3_stall_accepted_le2", (racc - acc0) <= 2, 1);
    @(posedge aclk); #1;
    oready = 1;
    wait_done("t3");
    tail("t3", d0);

    // Error response on beat 3, then cleared by the next start.
    bidx = 0; err_beat = 3;
    push_ar(32'h4000, 6'd7);
    push_xfer(32'h4000, 8);
    d0 = done_cnt;
    kick(32'h4000, 8);
    wait_done("t4");
    chk("t4_err_set", err, 1);
    tail("t4", d0);
    err_beat = 0;
    push_ar(32'h5000, 6'd3);
    push_xfer(32'h5000, 4);
    d0 = done_cnt;
    kick(32'h5000, 4);
    @(negedge aclk);
    chk("t4b_err_cleared", err, 0);
    wait_done("t4b");
    chk("t4b_err_still_clear", err, 0);
    tail("t4b", d0);

    // Zero-length request.
    d0 = done_cnt;
    kick(32'h6000, 0);
    @(negedge aclk);
    chk("t5_done_pulse", {done, busy, arvalid}, 3'b100);
    @(negedge aclk);
    chk("t5_done_off", {done, busy, arvalid}, 3'b000);
    tail("t5", d0);

    // Reset in the middle of a 16-beat burst.
    push_ar(32'h6000, 6'd15);
    push_xfer(32'h6000, 16);
    acc0 = racc;
    kick(32'h6000, 16);
    k = 0;
    while (racc - acc0 < 5 && k < 500) begin
      @(negedge aclk);
      k++;
    end
    if (k >= 500) fail("t6_wait_beats");
    @(posedge aclk); #1;
    arst = 1;
    @(posedge aclk);
    @(negedge aclk);
    chk("t6_rst_ctrl", {arvalid, rready, ovalid, olast, busy, done, err}, 0);
    chk("t6_rst_ar", {araddr, arlen, arsize, arburst, arid}, 0);
    chk("t6_rst_odata", odata, 0);
    chk("t6_ar_consumed", ar_q.size(), 0);
    exp_q.delete();
    @(posedge aclk); #1;
    arst = 0;
    repeat (2) @(posedge aclk);
    push_ar(32'h7000, 6'd7);
    push_xfer(32'h7000, 8);
    d0 = done_cnt;
    kick(32'h7000, 8);
    wait_done("t6b");
    chk("t6b_err", err, 0);
    tail("t6b", d0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
